truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Sequential stimulus-and-check stage for small combinational gate modules, such as the a'.b gate pair (gate-level and expression-level variants).
- Upstream: drives every input minterm in ascending order onto the gate inputs.
- Downstream: samples the two implementations' outputs and compares each against an expected truth table and against each other.
- Reports pass/fail, mismatch count and first failing minterm.
- Replaces the hand-written #1 stimulus lists in gate benches with a clocked, synthesizable sweep.

Parameters:
- N_IN, 2, number of gate inputs; minterm count M = 2^N_IN.
- EXPECT, 4'b0010, expected output per minterm, width M; bit m = expected s for minterm m; default is the a'.b table.
- SETTLE, 1, extra cycles to wait after applying a minterm before sampling; range 0..15.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous active-high reset.
- start, input, 1, begin a sweep; sampled only in IDLE.
- stim, output, N_IN, current minterm; MSB drives gate input a, LSB drives b.
- s_a, input, 1, output of implementation A (gate-level).
- s_b, input, 1, output of implementation B (expression-level).
- busy, output, 1, high while a sweep is in progress.
- done, output, 1, one-cycle pulse at sweep end.
- pass, output, 1, valid after done; 1 when no minterm failed.
- err_count, output, N_IN+1, number of failing minterms; range 0..M.
- fail_vld, output, 1, at least one minterm has failed.
- fail_minterm, output, N_IN, first failing minterm; meaningful only when fail_vld=1.
- impl_diff, output, 1, sticky flag: s_a != s_b was seen at some sample.

Behaviour:
- Clocking/reset: one clock (clk), synchronous active-high reset (reset); the polarity and synchronicity are fixed.
- Reset values (all registered): stim=0, busy=0, done=0, pass=0, err_count=0, fail_vld=0, fail_minterm=0, impl_diff=0; state=IDLE; settle counter=0.
- States: IDLE, WAIT, FIN.
- IDLE:
  - busy=0.
  - start=1: next state WAIT; stim<=0; cnt<=SETTLE; err_count, fail_vld, fail_minterm, impl_diff and pass cleared; busy<=1.
- WAIT:
  - cnt!=0: cnt<=cnt-1.
  - cnt==0: sample s_a/s_b against EXPECT[stim].
  - Minterm fails when s_a!=EXPECT[stim] or s_b!=EXPECT[stim]. A failing minterm increments err_count by 1 once, even if both implementations are wrong.
  - On the first fail: fail_vld<=1 and fail_minterm<=stim. Later fails do not overwrite fail_minterm.
  - s_a!=s_b sets impl_diff; it stays set until the next start or reset.
  - After the sample: if stim==M-1, go to FIN; else stim<=stim+1 and cnt<=SETTLE.
- Timing: each minterm is held exactly SETTLE+1 cycles.
- FIN:
  - done=1 for exactly one cycle; busy<=0.
  - pass<=1 when err_count==0, computed including the final minterm's result.
  - Next state IDLE.
  - stim holds M-1 until the next start.
- start while busy or in FIN is ignored; it is not queued.
- start held high continuously: a new sweep begins on the first IDLE cycle after FIN, so back-to-back sweeps are separated by the FIN cycle.
- Reset mid-sweep takes priority over everything: all outputs return to reset values on the next edge and no done pulse is issued.
- Latency, start sampled at edge 0: done high in cycle M*(SETTLE+1)+1. With defaults this is cycle 9.
- Arithmetic: err_count saturates naturally at M; no wrap is possible at width N_IN+1.

Optional Feature:
- Macro: SWEEPER_STOP_ON_FAIL_EN.
- Defined: the first failing sample ends the sweep. The next state is FIN, with err_count=1, fail_vld=1, fail_minterm=failing minterm, and stim held at that minterm.
- Undefined: the full sweep always runs over all M minterms, as described above.

Test Plan:
- Defaults, s_a/s_b from correct a'.b gates, start pulse at cycle 0 -> stim=0,1,2,3 each held 2 cycles; done pulse at cycle 9; pass=1, err_count=0, fail_vld=0, impl_diff=0.
- s_b tied 0, s_a correct -> minterm 1 fails; pass=0, err_count=1, fail_minterm=1, fail_vld=1, impl_diff=1.
- s_a=a&b and s_b=a&b (wrong function) -> minterms 1 and 3 fail; err_count=2, fail_minterm=1, impl_diff=0.
- reset asserted while stim=2, then released, then start -> no done before reset; all outputs 0 after reset; new sweep restarts at stim=0 with clean counters.
- start re-pulsed at cycles 3 and 5 during a busy sweep -> ignored; single done at cycle 9. Separately, SETTLE=0 -> one cycle per minterm; done at cycle 5.
- SWEEPER_STOP_ON_FAIL_EN defined, s_b tied 0 -> done at cycle 5; stim=1, err_count=1, pass=0.

Source files
------------

// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: clocked minterm sweep that checks two gate implementations against a truth table.
// Optional SWEEPER_STOP_ON_FAIL_EN ends the sweep at the first failing minterm.
module truth_table_sweeper #(
  parameter int N_IN = 2,
  parameter logic [2**N_IN-1:0] EXPECT = 4'b0010,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            s_a,
  input  logic            s_b,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic            fail_vld,
  output logic [N_IN-1:0] fail_minterm,
  output logic            impl_diff
);
  localparam int M = 2**N_IN;
`ifdef SWEEPER_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, WAIT, FIN} state_t;
  state_t state_q, state_d;
  logic [N_IN-1:0] stim_q, stim_d, fail_min_q, fail_min_d;
  logic [N_IN:0] err_q, err_d;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, pass_q, pass_d, fail_vld_q, fail_vld_d, diff_q, diff_d;
  logic go, sample, exp_bit, bad, last, adv;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      stim_q     <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
      fail_vld_q <= 1'b0;
      fail_min_q <= '0;
      diff_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
      fail_vld_q <= fail_vld_d;
      fail_min_q <= fail_min_d;
      diff_q     <= diff_d;
    end
  end
  always_comb begin
    go      = state_q == IDLE && start;
    sample  = state_q == WAIT && cnt_q == 4'd0;
    exp_bit = EXPECT[stim_q];
    bad     = sample && (s_a != exp_bit || s_b != exp_bit);
    last    = stim_q == N_IN'(M-1);
    state_d = state_q == IDLE ? (start ? WAIT : IDLE) :
              state_q == WAIT ? ((sample && (last || (STOP && bad))) ? FIN : WAIT) : IDLE;
  end
  // Counters and flags clear on start; results of the final sample land together with the FIN entry.
  always_comb begin
    adv        = sample && state_d == WAIT;
    stim_d     = go ? '0 : adv ? stim_q + N_IN'(1) : stim_q;
    cnt_d      = (go || adv) ? 4'(SETTLE) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    err_d      = go ? '0 : err_q + (N_IN+1)'(bad);
    fail_vld_d = !go && (fail_vld_q || bad);
    fail_min_d = go ? '0 : (bad && !fail_vld_q) ? stim_q : fail_min_q;
    diff_d     = !go && (diff_q || (sample && s_a != s_b));
    busy_d     = state_d == WAIT;
    done_d     = state_d == FIN;
    pass_d     = go ? 1'b0 : state_d == FIN ? err_d == '0 : pass_q;
  end
  assign stim         = stim_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign pass         = pass_q;
  assign err_count    = err_q;
  assign fail_vld     = fail_vld_q;
  assign fail_minterm = fail_min_q;
  assign impl_diff    = diff_q;
endmodule
